// File: rtl/wireframe_scanout.sv
// rtl/wireframe_scanout.sv - raster-order frame buffer scan-out with optional clear-on-read
//
// Ports:
//   clk, n_rst         clock, synchronous active-low reset
//   start, clear_en    begin a frame scan; clear_en sampled with start
//   busy, frame_done   scan in progress / one-cycle end-of-frame pulse
//   sram_addr          SRAM address, shared by read and clear-write
//   sram_write_en      SRAM write strobe (clear mode issue cycles only)
//   sram_data_in       SRAM write data, always 0
//   sram_data_out      SRAM read data, one cycle after the address
//   pix_valid/ready    output pixel stream handshake
//   pix_data, pix_x, pix_y, pix_sof, pix_eol   pixel payload and markers
module wireframe_scanout #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic                      clear_en,
  output logic                      busy,
  output logic                      frame_done,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic                      sram_write_en,
  output logic                      sram_data_in,
  input  logic                      sram_data_out,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      pix_data,
  output logic [$clog2(WIDTH)-1:0]  pix_x,
  output logic [$clog2(HEIGHT)-1:0] pix_y,
  output logic                      pix_sof,
  output logic                      pix_eol
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
  localparam logic [XW-1:0]         X_LAST    = XW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic          data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
  } entry_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic                  clr;

  // tags of the read currently in flight, aligned with sram_data_out
  logic                  inflight;
  logic [XW-1:0]         tag_x;
  logic [YW-1:0]         tag_y;
  logic                  tag_sof;
  logic                  tag_eol;

  entry_t                fifo [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  logic                  pop;
  logic                  push;
  logic                  issue;
  entry_t                head;

  assign pop  = pix_valid & pix_ready;
  assign push = inflight;

  // Credit rule: entries held plus the read in flight, minus the one leaving
  // this cycle, must leave room; written without subtraction to stay unsigned.
  assign issue = n_rst && (state == SCAN) &&
                 (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign sram_addr     = issue ? addr : addr_hold;
  assign sram_write_en = issue & clr;
  assign sram_data_in  = 1'b0;

  assign pix_valid = (count != 2'd0);
  assign head      = fifo[rd_ptr];
  // payload is forced to zero when nothing is presented so reset/idle is clean
  assign pix_data  = pix_valid & head.data;
  assign pix_x     = pix_valid ? head.x : '0;
  assign pix_y     = pix_valid ? head.y : '0;
  assign pix_sof   = pix_valid & head.sof;
  assign pix_eol   = pix_valid & head.eol;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      addr       <= '0;
      addr_hold  <= '0;
      x          <= '0;
      y          <= '0;
      clr        <= 1'b0;
      inflight   <= 1'b0;
      tag_x      <= '0;
      tag_y      <= '0;
      tag_sof    <= 1'b0;
      tag_eol    <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      frame_done <= 1'b0;
      inflight   <= issue;

      if (issue) begin
        tag_x     <= x;
        tag_y     <= y;
        tag_sof   <= (addr == '0);
        tag_eol   <= (x == X_LAST);
        addr_hold <= addr;
      end

      if (push) begin
        fifo[wr_ptr] <= '{data: sram_data_out, x: tag_x, y: tag_y, sof: tag_sof, eol: tag_eol};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: begin
          // frame_done still high means the previous frame ends this cycle
          if (start && !frame_done) begin
            state <= SCAN;
            busy  <= 1'b1;
            addr  <= '0;
            x     <= '0;
            y     <= '0;
            clr   <= clear_en;
          end
        end
        SCAN: begin
          if (issue) begin
            if (addr == LAST_ADDR) begin
              state <= DRAIN;
            end else begin
              addr <= addr + 1'b1;
              if (x == X_LAST) begin
                x <= '0;
                y <= y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          // finish on the edge of the last handshake so frame_done follows it directly
          if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wireframe_scanout.sv
// tb/tb_wireframe_scanout.sv - self-checking bench for wireframe_scanout
module tb_wireframe_scanout;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          n_rst, start, clear_en;
  logic          busy, frame_done;
  logic [AW-1:0] sram_addr;
  logic          sram_write_en, sram_data_in, sram_data_out;
  logic          pix_valid, pix_ready, pix_data, pix_sof, pix_eol;
  logic [1:0]    pix_x, pix_y;

  always #5 clk = ~clk;

  wireframe_scanout #(.WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .clear_en(clear_en),
    .busy(busy), .frame_done(frame_done),
    .sram_addr(sram_addr), .sram_write_en(sram_write_en),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol)
  );

  typedef struct packed {
    logic       data;
    logic [1:0] x;
    logic [1:0] y;
    logic       sof;
    logic       eol;
  } pix_t;

  typedef struct {
    pix_t p;
    int   cyc;
  } obs_t;

  pix_t exp_q[$];
  obs_t obs_q[$];

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int fd_count  = 0;
  int fd_cyc    = 0;
  int stall_err = 0;
  int last_wr   = -1;

  logic [15:0] mem;
  logic        do_load;
  logic [15:0] load_val;
  logic        prev_stall = 1'b0;
  pix_t        prev_p;

  // read-before-write SRAM model
  always @(posedge clk) begin
    if (do_load) mem <= load_val;
    else if (sram_write_en) mem[sram_addr] <= sram_data_in;
    sram_data_out <= mem[sram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pix_t cur;
    obs_t o;
    cur = {pix_data, pix_x, pix_y, pix_sof, pix_eol};
    if (n_rst === 1'b1) begin
      if (prev_stall && (pix_valid !== 1'b1 || cur !== prev_p)) stall_err++;
      if (pix_valid && pix_ready) begin
        o.p = cur;
        o.cyc = cyc;
        obs_q.push_back(o);
      end
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (sram_write_en) last_wr = int'(sram_addr);
      prev_stall = pix_valid && !pix_ready;
      prev_p = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    load_val = v;
    do_load  = 1'b1;
    tick();
    do_load  = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] img);
    pix_t e;
    for (int i = 0; i < N; i++) begin
      e.data = img[i];
      e.x    = 2'(i % W);
      e.y    = 2'(i / W);
      e.sof  = (i == 0);
      e.eol  = ((i % W) == W - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input logic ce, output int s);
    start    = 1'b1;
    clear_en = ce;
    s        = cyc;
    tick();
    start    = 1'b0;
    clear_en = 1'b0;
  endtask

  task automatic wait_done(input int fd0, input int budget, output bit ok);
    for (int k = 0; k < budget && fd_count == fd0; k++) tick();
    ok = (fd_count != fd0);
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start = 1'b1; clear_en = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, frame_done, pix_valid, sram_write_en, sram_addr, pix_x, pix_y,
           pix_sof, pix_eol, pix_data} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: busy=%b fd=%b pv=%b we=%b addr=%0d x=%0d y=%0d sof=%b eol=%b d=%b, required all 0",
                 i, busy, frame_done, pix_valid, sram_write_en, sram_addr, pix_x, pix_y,
                 pix_sof, pix_eol, pix_data);
      end
    end
    tick();
    start = 1'b0; clear_en = 1'b0; n_rst = 1'b1;
    tick();
  endtask

  task automatic test_full_rate;
    int s; int fd0; bit ok; obs_t o; pix_t e;
    load(16'hAAAA);
    obs_q.delete(); exp_q.delete();
    push_frame(16'hAAAA);
    pix_ready = 1'b1;
    fd0 = fd_count;
    start_frame(1'b0, s);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_after_start: got %b, required 1", busy); end
    wait_done(fd0, 100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_timeout: frame_done count %0d, required %0d", fd_count, fd0 + 1); end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL full_px%0d: got no pixel, required %b", i, e);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e) begin failures++; $display("FAIL full_px%0d: got %b, required %b", i, o.p, e); end
        checks++;
        if (o.cyc !== s + 3 + i) begin failures++; $display("FAIL full_px%0d_cycle: got %0d, required %0d", i, o.cyc, s + 3 + i); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL full_extra: got %0d extra pixels, required 0", obs_q.size()); end
    checks++;
    if (fd_cyc !== s + 3 + N) begin failures++; $display("FAIL full_done_cycle: got %0d, required %0d", fd_cyc, s + 3 + N); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_read_clear;
    int s; int fd0; bit ok; obs_t o; pix_t e;
    load(16'hFFFF);
    for (int f = 0; f < 2; f++) begin
      obs_q.delete(); exp_q.delete();
      push_frame(f == 0 ? 16'hFFFF : 16'h0000);
      fd0 = fd_count;
      start_frame(f == 0, s);
      wait_done(fd0, 100, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL clear_f%0d_timeout: no frame_done", f); end
      for (int i = 0; i < N; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
          failures++; $display("FAIL clear_f%0d_px%0d: got no pixel, required %b", f, i, e);
        end else begin
          o = obs_q.pop_front();
          if (o.p !== e) begin failures++; $display("FAIL clear_f%0d_px%0d: got %b, required %b", f, i, o.p, e); end
        end
      end
      checks++;
      if (mem !== 16'hF000) begin failures++; $display("FAIL clear_f%0d_mem: got %h, required f000", f, mem); end
    end
  endtask

  task automatic test_backpressure;
    int s; int fd0; bit ok; obs_t o; pix_t e;
    load(16'h5A3C);
    obs_q.delete(); exp_q.delete();
    push_frame(16'h5A3C);
    stall_err = 0;
    fd0 = fd_count;
    pix_ready = 1'b0;
    start_frame(1'b0, s);
    for (int k = 0; k < 300 && fd_count == fd0; k++) begin
      pix_ready = (k >= 8 && k < 13) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
    end
    pix_ready = 1'b1;
    ok = (fd_count != fd0);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout: no frame_done"); end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL bp_px%0d: got no pixel, required %b", i, e);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e) begin failures++; $display("FAIL bp_px%0d: got %b, required %b", i, o.p, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL bp_extra: got %0d extra pixels, required 0", obs_q.size()); end
    checks++;
    if (stall_err != 0) begin failures++; $display("FAIL bp_stable: got %0d payload changes while stalled, required 0", stall_err); end
  endtask

  task automatic test_start_busy;
    int s; int fd0; bit ok; obs_t o; pix_t e;
    load(16'h3333);
    obs_q.delete(); exp_q.delete();
    push_frame(16'h3333);
    fd0 = fd_count;
    pix_ready = 1'b1;
    start_frame(1'b0, s);
    for (int k = 0; k < 100 && obs_q.size() < 5; k++) tick();
    start = 1'b1; clear_en = 1'b1;
    tick();
    start = 1'b0; clear_en = 1'b0;
    wait_done(fd0, 100, ok);
    repeat (20) tick();
    checks++;
    if (fd_count !== fd0 + 1) begin failures++; $display("FAIL busy_start_done_count: got %0d, required %0d", fd_count - fd0, 1); end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL busy_start_px%0d: got no pixel, required %b", i, e);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e) begin failures++; $display("FAIL busy_start_px%0d: got %b, required %b", i, o.p, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL busy_start_extra: got %0d extra pixels, required 0", obs_q.size()); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle: busy %b, required 0", busy); end
    checks++;
    if (mem !== 16'h3333) begin failures++; $display("FAIL busy_start_mem: got %h, required 3333", mem); end
  endtask

  task automatic test_reset_mid;
    int s; int fd0; bit ok; obs_t o; pix_t e; logic [15:0] expv;
    load(16'hFFFF);
    obs_q.delete(); exp_q.delete();
    last_wr = -1;
    pix_ready = 1'b1;
    start_frame(1'b1, s);
    for (int k = 0; k < 100 && obs_q.size() < 7; k++) tick();
    n_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, frame_done, pix_valid, sram_write_en, sram_addr, pix_x, pix_y,
         pix_sof, pix_eol, pix_data} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: busy=%b pv=%b we=%b addr=%0d x=%0d y=%0d, required all 0",
               busy, pix_valid, sram_write_en, sram_addr, pix_x, pix_y);
    end
    checks++;
    if (last_wr < 6 || last_wr > 8) begin failures++; $display("FAIL midrst_last_addr: got %0d, required 6..8", last_wr); end
    for (int a = 0; a < 16; a++) expv[a] = (a > last_wr);
    checks++;
    if (mem !== expv) begin failures++; $display("FAIL midrst_mem: got %h, required %h", mem, expv); end
    tick();
    n_rst = 1'b1;
    tick();
    obs_q.delete();
    push_frame(expv);
    fd0 = fd_count;
    start_frame(1'b0, s);
    wait_done(fd0, 100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_timeout: no frame_done"); end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL midrst_px%0d: got no pixel, required %b", i, e);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e) begin failures++; $display("FAIL midrst_px%0d: got %b, required %b", i, o.p, e); end
        if (i == 0) begin
          checks++;
          if (o.cyc !== s + 3) begin failures++; $display("FAIL midrst_first_cycle: got %0d, required %0d", o.cyc, s + 3); end
        end
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; clear_en = 1'b0; pix_ready = 1'b1;
    do_load = 1'b0; load_val = '0;
    test_reset();
    test_full_rate();
    test_read_clear();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
